// File: rtl/cdb_arbiter.sv
// cdb_arbiter: single-port CDB arbiter, one registered broadcast per cycle.
// Optional macro CDB_ARB_OLDEST_FIRST_EN selects oldest-first over round-robin.
package cdb_pkg;
  localparam int TOTAL_FU = 6;
  localparam int FU_ID_W  = 3;

  typedef struct packed {
    logic               valid;
    logic [FU_ID_W-1:0] fu_id;
    logic [4:0]         rd;
    logic [31:0]        data;
    logic [63:0]        order;
  } cdb_entry_t;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ   = TOTAL_FU,
  parameter int CNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic       [NUM_REQ-1:0]     req_valid,
  input  cdb_entry_t [NUM_REQ-1:0]     req_entry,
  output logic       [NUM_REQ-1:0]     req_ready,
  output cdb_entry_t                   cdb_out,
  output logic       [CNT_WIDTH-1:0]   grant_count,
  output logic       [CNT_WIDTH-1:0]   conflict_cycles
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] win;
  logic          hit;
  logic          grant;
  logic          conflict;
  cdb_entry_t    nxt;

`ifdef CDB_ARB_OLDEST_FIRST_EN
  logic [63:0] best;

  // Oldest-first: smallest order wins, ties go to the lowest index.
  always_comb begin
    win  = '0;
    hit  = 1'b0;
    best = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && (!hit || req_entry[i].order < best)) begin
        hit  = 1'b1;
        win  = IW'(i);
        best = req_entry[i].order;
      end
    end
  end
`else
  int idx;

  // Round-robin: first valid index at or after rr_ptr, wrapping.
  always_comb begin
    win = '0;
    hit = 1'b0;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!hit && req_valid[idx]) begin
        hit = 1'b1;
        win = IW'(idx);
      end
    end
  end
`endif

  // Grant is suppressed by flush and while reset is held.
  always_comb begin
    grant     = hit && !flush && rst_n;
    conflict  = !flush && ($countones(req_valid) >= 2);
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant && (win == IW'(i));
    end
  end

  // Winner payload with valid and fu_id overridden.
  always_comb begin
    nxt       = req_entry[win];
    nxt.valid = 1'b1;
    nxt.fu_id = FU_ID_W'(win);
  end

  // Broadcast register, pointer and performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_out         <= '0;
      rr_ptr          <= '0;
      grant_count     <= '0;
      conflict_cycles <= '0;
    end else begin
      if (grant) begin
        cdb_out     <= nxt;
        rr_ptr      <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        grant_count <= grant_count + 1'b1;
      end else begin
        cdb_out.valid <= 1'b0;
      end
      if (conflict) begin
        conflict_cycles <= conflict_cycles + 1'b1;
      end
    end
  end

endmodule
